axi_read_arb2: RTL and testbench

Two-to-one AXI read-channel arbiter that shares the single instruction-memory AXI read slave between two masters, typically the icache refill engine (port 0) and a secondary fetch/debug master (port 1). Selects one master per transaction, forwards its AR handshake, and routes the whole R burst back to it. The grant is held until the last beat completes. Optional round-robin fairness. A sticky flag reports burst-length protocol errors.

---
 rtl/axi_read_if.sv | 30 +++
 rtl/axi_read_arb2.sv | 149 ++++++++++++++
 tb/tb_axi_read_arb2.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_read_if.sv
// AXI read-channel (AR + R) bundle shared by the instruction-memory path.
// master drives the request side, slave drives the response side.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

interface axi_read_if #(
  parameter int ADDR_W = `AXI_ADDR_WIDTH,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arlen, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi_read_arb2.sv
// Two-to-one AXI read arbiter: grant held for a whole burst.
// Macro AXI_ARB_ROUND_ROBIN_EN selects round-robin, else port 0 wins ties.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

module axi_read_arb2 #(
  parameter int ADDR_W = `AXI_ADDR_WIDTH,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  axi_read_if.slave  m0_if,
  axi_read_if.slave  m1_if,
  axi_read_if.master s_if,
  output logic       grant,
  output logic       busy,
  output logic       proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic [7:0] len_q, len_d;
  logic [7:0] beat_q, beat_d;
  logic       perr_q, perr_d;

  logic              req0, req1, win;
  logic              in_ar, in_r;
  logic              sel_arvalid, sel_rready;
  logic [ADDR_W-1:0] sel_araddr;
  logic [7:0]        sel_arlen;
  logic              rhs;

  assign req0  = m0_if.arvalid;
  assign req1  = m1_if.arvalid;
  assign in_ar = (state_q == AR);
  assign in_r  = (state_q == R);

  assign sel_arvalid = grant_q ? m1_if.arvalid : m0_if.arvalid;
  assign sel_araddr  = grant_q ? m1_if.araddr  : m0_if.araddr;
  assign sel_arlen   = grant_q ? m1_if.arlen   : m0_if.arlen;
  assign sel_rready  = grant_q ? m1_if.rready  : m0_if.rready;

  assign rhs = s_if.rvalid & sel_rready;

  // Winner of the next arbitration round.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      req0 & req1: begin
`ifdef AXI_ARB_ROUND_ROBIN_EN
        win = ~last_q;
`else
        win = 1'b0;
`endif
      end
      req1 & ~req0: win = 1'b1;
      default:      win = 1'b0;
    endcase
  end

  // Next-state and bookkeeping for the arbitration FSM.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    len_d   = len_q;
    beat_d  = beat_q;
    perr_d  = perr_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant_d = win;
          state_d = AR;
        end
      end
      AR: begin
        if (sel_arvalid & s_if.arready) begin
          len_d   = sel_arlen;
          beat_d  = 8'd0;
          state_d = R;
        end
      end
      R: begin
        if (rhs) begin
          beat_d = beat_q + 8'd1;
          if (s_if.rlast && beat_q != len_q)
            perr_d = 1'b1;
          if (!s_if.rlast && beat_q == len_q)
            perr_d = 1'b1;
          if (s_if.rlast) begin
            last_d  = grant_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and arbitration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      len_q   <= 8'd0;
      beat_q  <= 8'd0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      perr_q  <= perr_d;
    end
  end

  assign s_if.arvalid = in_ar & sel_arvalid;
  assign s_if.araddr  = in_ar ? sel_araddr : '0;
  assign s_if.arlen   = in_ar ? sel_arlen  : 8'd0;
  assign s_if.rready  = in_r & sel_rready;

  assign m0_if.arready = in_ar & ~grant_q & s_if.arready;
  assign m0_if.rvalid  = in_r & ~grant_q & s_if.rvalid;
  assign m0_if.rlast   = in_r & ~grant_q & s_if.rlast;
  assign m0_if.rdata   = (in_r & ~grant_q) ? s_if.rdata : '0;
  assign m0_if.rresp   = (in_r & ~grant_q) ? s_if.rresp : 2'b00;

  assign m1_if.arready = in_ar & grant_q & s_if.arready;
  assign m1_if.rvalid  = in_r & grant_q & s_if.rvalid;
  assign m1_if.rlast   = in_r & grant_q & s_if.rlast;
  assign m1_if.rdata   = (in_r & grant_q) ? s_if.rdata : '0;
  assign m1_if.rresp   = (in_r & grant_q) ? s_if.rresp : 2'b00;

  assign grant     = grant_q;
  assign busy      = in_ar | in_r;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_axi_read_arb2.sv
// Directed bench for axi_read_arb2.
// Inputs driven and outputs sampled around the falling edge.
module tb_axi_read_arb2;

  logic clk = 1'b0;
  logic rst_n;
  logic grant, busy, proto_err;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axi_read_if m0_if ();
  axi_read_if m1_if ();
  axi_read_if s_if ();

  axi_read_arb2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_if     (m0_if),
    .m1_if     (m1_if),
    .s_if      (s_if),
    .grant     (grant),
    .busy      (busy),
    .proto_err (proto_err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] dat(input int i);
    return 32'hD000_0000 + i;
  endfunction

  function automatic logic mrvalid(input int m);
    return (m == 1) ? m1_if.rvalid : m0_if.rvalid;
  endfunction

  function automatic logic orvalid(input int m);
    return (m == 1) ? m0_if.rvalid : m1_if.rvalid;
  endfunction

  function automatic logic mrlast(input int m);
    return (m == 1) ? m1_if.rlast : m0_if.rlast;
  endfunction

  function automatic logic [31:0] mrdata(input int m);
    return (m == 1) ? m1_if.rdata : m0_if.rdata;
  endfunction

  task automatic set_req(input int m, input logic v,
                         input logic [31:0] a, input logic [7:0] l);
    if (m == 1) begin
      m1_if.arvalid = v; m1_if.araddr = a; m1_if.arlen = l;
    end else begin
      m0_if.arvalid = v; m0_if.araddr = a; m0_if.arlen = l;
    end
  endtask

  task automatic set_rready(input int m, input logic v);
    if (m == 1) m1_if.rready = v;
    else m0_if.rready = v;
  endtask

  task automatic wait_ar(output int lat);
    lat = 0;
    while (s_if.arvalid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Slave-side beat driver; reports delivery problems to the caller.
  task automatic serve(input int m, input int n, input int last_at,
                       input int stall_at, input int stall_n,
                       output int beats, output int errs, output int lowcnt);
    beats = 0; errs = 0; lowcnt = 0;
    for (int i = 0; i < n; i++) begin
      s_if.rvalid = 1'b1;
      s_if.rdata  = dat(i);
      s_if.rlast  = (i == last_at);
      s_if.rresp  = 2'b00;
      if (i == stall_at) begin
        set_rready(m, 1'b0);
        for (int k = 0; k < stall_n; k++) begin
          #1;
          if (s_if.rready === 1'b0) lowcnt++;
          if (mrdata(m) !== dat(i) || mrvalid(m) !== 1'b1) errs++;
          tick();
        end
        set_rready(m, 1'b1);
      end
      #1;
      if (mrvalid(m) !== 1'b1 || mrdata(m) !== dat(i)) errs++;
      if (mrlast(m) !== (i == last_at)) errs++;
      if (orvalid(m) !== 1'b0 || s_if.rready !== 1'b1) errs++;
      tick();
      beats++;
    end
    s_if.rvalid = 1'b0;
    s_if.rlast  = 1'b0;
    s_if.rdata  = '0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (busy !== 1'b0 || grant !== 1'b0 || proto_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_outs busy=%b grant=%b perr=%b want 0 0 0",
               busy, grant, proto_err);
    end
    tests++;
    if (s_if.arvalid !== 1'b0 || m0_if.arready !== 1'b0 ||
        s_if.rready !== 1'b0) begin
      fails++;
      $display("FAIL reset_bus s.arvalid=%b m0.arready=%b s.rready=%b want 0",
               s_if.arvalid, m0_if.arready, s_if.rready);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int b, e, lo;
    set_req(0, 1'b1, 32'h100, 8'd7);
    #1;
    tests++;
    if (s_if.arvalid !== 1'b0) begin
      fails++;
      $display("FAIL single_lat0 s.arvalid=%b want 0", s_if.arvalid);
    end
    tick();
    #1;
    tests++;
    if (s_if.arvalid !== 1'b1 || s_if.araddr !== 32'h100 ||
        s_if.arlen !== 8'd7) begin
      fails++;
      $display("FAIL single_ar v=%b addr=%h len=%0d want 1 100 7",
               s_if.arvalid, s_if.araddr, s_if.arlen);
    end
    tests++;
    if (grant !== 1'b0 || busy !== 1'b1 || m0_if.arready !== 1'b1 ||
        m1_if.arready !== 1'b0) begin
      fails++;
      $display("FAIL single_grant g=%b busy=%b rdy0=%b rdy1=%b want 0 1 1 0",
               grant, busy, m0_if.arready, m1_if.arready);
    end
    tick();
    set_req(0, 1'b0, 32'h0, 8'd0);
    serve(0, 8, 7, -1, 0, b, e, lo);
    tests++;
    if (b != 8 || e != 0) begin
      fails++;
      $display("FAIL single_beats beats=%0d errs=%0d want 8 0", b, e);
    end
    tests++;
    if (busy !== 1'b0 || grant !== 1'b0 || proto_err !== 1'b0) begin
      fails++;
      $display("FAIL single_end busy=%b grant=%b perr=%b want 0 0 0",
               busy, grant, proto_err);
    end
    tick();
  endtask

  task automatic test_contention();
    int exp_g[3];
    int rem0, rem1, lat, b, e, lo;
    logic [31:0] a0, exp_a;
`ifdef AXI_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0};
`else
    exp_g = '{0, 0, 1};
`endif
    rem0 = 2;
    rem1 = 1;
    a0 = 32'h200;
    set_req(0, 1'b1, a0, 8'd7);
    set_req(1, 1'b1, 32'h340, 8'd7);
    for (int t = 0; t < 3; t++) begin
      wait_ar(lat);
      exp_a = (exp_g[t] == 1) ? 32'h340 : a0;
      tests++;
      if (s_if.arvalid !== 1'b1 || grant !== exp_g[t][0] || lat != 1) begin
        fails++;
        $display("FAIL contend_grant%0d v=%b g=%b lat=%0d want 1 %0d 1",
                 t, s_if.arvalid, grant, lat, exp_g[t]);
      end
      tests++;
      if (s_if.araddr !== exp_a) begin
        fails++;
        $display("FAIL contend_addr%0d addr=%h want %h", t, s_if.araddr, exp_a);
      end
      tick();
      if (exp_g[t] == 1) begin
        rem1--;
        if (rem1 == 0) set_req(1, 1'b0, 32'h0, 8'd0);
      end else begin
        rem0--;
        a0 = 32'h280;
        if (rem0 == 0) set_req(0, 1'b0, 32'h0, 8'd0);
        else set_req(0, 1'b1, a0, 8'd7);
      end
      serve(exp_g[t], 8, 7, -1, 0, b, e, lo);
      tests++;
      if (b != 8 || e != 0) begin
        fails++;
        $display("FAIL contend_beats%0d beats=%0d errs=%0d want 8 0", t, b, e);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat, b, e, lo;
    set_req(0, 1'b1, 32'h400, 8'd7);
    wait_ar(lat);
    tests++;
    if (s_if.arvalid !== 1'b1 || grant !== 1'b0) begin
      fails++;
      $display("FAIL bp_ar v=%b g=%b want 1 0", s_if.arvalid, grant);
    end
    tick();
    set_req(0, 1'b0, 32'h0, 8'd0);
    serve(0, 8, 7, 2, 3, b, e, lo);
    tests++;
    if (b != 8 || e != 0 || lo != 3) begin
      fails++;
      $display("FAIL bp_beats beats=%0d errs=%0d low=%0d want 8 0 3",
               b, e, lo);
    end
    tick();
  endtask

  task automatic test_proto_err();
    int lat, b, e, lo;
    tests++;
    if (proto_err !== 1'b0) begin
      fails++;
      $display("FAIL perr_pre perr=%b want 0", proto_err);
    end
    set_req(0, 1'b1, 32'h500, 8'd7);
    wait_ar(lat);
    tick();
    set_req(0, 1'b0, 32'h0, 8'd0);
    serve(0, 4, 3, -1, 0, b, e, lo);
    tests++;
    if (b != 4 || e != 0) begin
      fails++;
      $display("FAIL perr_beats beats=%0d errs=%0d want 4 0", b, e);
    end
    tests++;
    if (proto_err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL perr_set perr=%b busy=%b want 1 0", proto_err, busy);
    end
    tick();
    tick();
    tests++;
    if (proto_err !== 1'b1) begin
      fails++;
      $display("FAIL perr_sticky perr=%b want 1", proto_err);
    end
  endtask

  task automatic test_reset_mid();
    int lat, b, e, lo;
    set_req(1, 1'b1, 32'h600, 8'd7);
    wait_ar(lat);
    tests++;
    if (grant !== 1'b1) begin
      fails++;
      $display("FAIL rmid_grant g=%b want 1", grant);
    end
    tick();
    set_req(1, 1'b0, 32'h0, 8'd0);
    serve(1, 2, 7, -1, 0, b, e, lo);
    s_if.rvalid = 1'b1;
    s_if.rdata  = dat(2);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || grant !== 1'b0 || proto_err !== 1'b0) begin
      fails++;
      $display("FAIL rmid_state busy=%b g=%b perr=%b want 0 0 0",
               busy, grant, proto_err);
    end
    tests++;
    if (m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b0 ||
        s_if.arvalid !== 1'b0 || s_if.rready !== 1'b0 ||
        m1_if.rdata !== 32'h0) begin
      fails++;
      $display("FAIL rmid_valids rv0=%b rv1=%b arv=%b rrdy=%b want 0",
               m0_if.rvalid, m1_if.rvalid, s_if.arvalid, s_if.rready);
    end
    tick();
    s_if.rvalid = 1'b0;
    s_if.rdata  = '0;
    rst_n = 1'b1;
    tick();
    set_req(1, 1'b1, 32'h700, 8'd3);
    wait_ar(lat);
    tests++;
    if (s_if.arvalid !== 1'b1 || grant !== 1'b1 || s_if.araddr !== 32'h700 ||
        lat != 1) begin
      fails++;
      $display("FAIL rmid_regrant v=%b g=%b addr=%h lat=%0d want 1 1 700 1",
               s_if.arvalid, grant, s_if.araddr, lat);
    end
    tick();
    set_req(1, 1'b0, 32'h0, 8'd0);
    serve(1, 4, 3, -1, 0, b, e, lo);
    tests++;
    if (b != 4 || e != 0 || proto_err !== 1'b0) begin
      fails++;
      $display("FAIL rmid_burst beats=%0d errs=%0d perr=%b want 4 0 0",
               b, e, proto_err);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    set_req(0, 1'b0, 32'h0, 8'd0);
    set_req(1, 1'b0, 32'h0, 8'd0);
    m0_if.rready  = 1'b1;
    m1_if.rready  = 1'b1;
    s_if.arready  = 1'b1;
    s_if.rvalid   = 1'b0;
    s_if.rdata    = '0;
    s_if.rresp    = 2'b00;
    s_if.rlast    = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_proto_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
